// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//
// Shares one single-port synchronous framebuffer RAM between the VGA
// scan-out fetcher (reads, real-time) and an image writer (writes). The RAM
// holds two images; the front image is scanned out while the writer fills
// the back image. Buffer swaps are deferred to frame_start so the display
// never tears.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   image_select    requested front buffer (level)
//   frame_start     one-cycle pulse at start of vertical blanking
//   vga_req/addr    scan-out read request and pixel address
//   vga_gnt         read accepted this cycle (VGA has strict priority)
//   vga_rvalid/rdata read return, MEM_LAT+1 cycles after the grant cycle
//   wr_req/addr/data writer request, pixel address and data
//   wr_gnt          write accepted this cycle
//   mem_addr/we/wdata registered RAM command, mem_addr MSB = buffer select
//   mem_rdata       RAM read data
//   front_buf       buffer currently displayed
//   swap_pending    a swap has been requested and waits for frame_start
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 24,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              image_select,
    input  logic              frame_start,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic [ADDR_W:0]   mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              front_buf,
    output logic              swap_pending
);

    typedef enum logic [1:0] {
        SHOW0 = 2'b00,
        SHOW1 = 2'b01,
        PEND0 = 2'b10,
        PEND1 = 2'b11
    } swap_state_e;

    swap_state_e       state_q, state_d;
    logic [ADDR_W:0]   mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    // tag_q[k] set means a read granted k+1 cycles ago is still in flight
    logic [MEM_LAT:0]  tag_q, tag_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              front_s;
    logic              pend_s;
    logic              vga_gnt_s;
    logic              wr_gnt_s;

    // Arbitration: the scan-out side always wins, the writer waits
    assign vga_gnt_s = vga_req;
    assign wr_gnt_s  = wr_req & ~vga_req;

    // Decode displayed buffer and pending flag from the swap state
    always_comb begin
        front_s = 1'b0;
        pend_s  = 1'b0;
        case (state_q)
            SHOW0: begin front_s = 1'b0; pend_s = 1'b0; end
            SHOW1: begin front_s = 1'b1; pend_s = 1'b0; end
            PEND0: begin front_s = 1'b0; pend_s = 1'b1; end
            PEND1: begin front_s = 1'b1; pend_s = 1'b1; end
            default: begin front_s = 1'b0; pend_s = 1'b0; end
        endcase
    end

    // Swap FSM next state; a cancel (image_select back to the shown buffer)
    // takes precedence over a coincident frame_start
    always_comb begin
        state_d = state_q;
        case (state_q)
            SHOW0: begin
                if (image_select) state_d = PEND0;
                else              state_d = SHOW0;
            end
            SHOW1: begin
                if (!image_select) state_d = PEND1;
                else               state_d = SHOW1;
            end
            PEND0: begin
                if (!image_select)    state_d = SHOW0;
                else if (frame_start) state_d = SHOW1;
                else                  state_d = PEND0;
            end
            PEND1: begin
                if (image_select)     state_d = SHOW1;
                else if (frame_start) state_d = SHOW0;
                else                  state_d = PEND1;
            end
            default: state_d = SHOW0;
        endcase
    end

    // Memory command for next cycle; the buffer bit is the one shown now,
    // so a grant coinciding with the swapping frame_start uses the old buffer
    always_comb begin
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        if (vga_gnt_s) begin
            mem_addr_d = {front_s, vga_addr};
        end else if (wr_gnt_s) begin
            mem_addr_d  = {~front_s, wr_addr};
            mem_we_d    = 1'b1;
            mem_wdata_d = wr_data;
        end else begin
            mem_addr_d = mem_addr_q;
        end
    end

    // Read-tag shift register and read-data hold register next state
    always_comb begin
        tag_d = {tag_q[MEM_LAT-1:0], vga_gnt_s};
        if (tag_q[MEM_LAT]) rdata_d = mem_rdata;
        else                rdata_d = rdata_q;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SHOW0;
            mem_addr_q  <= {(ADDR_W+1){1'b0}};
            mem_we_q    <= 1'b0;
            mem_wdata_q <= {DATA_W{1'b0}};
            tag_q       <= {(MEM_LAT+1){1'b0}};
            rdata_q     <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            tag_q       <= tag_d;
            rdata_q     <= rdata_d;
        end
    end

    assign vga_gnt      = vga_gnt_s;
    assign wr_gnt       = wr_gnt_s;
    assign mem_addr     = mem_addr_q;
    assign mem_we       = mem_we_q;
    assign mem_wdata    = mem_wdata_q;
    assign front_buf    = front_s;
    assign swap_pending = pend_s;
    assign vga_rvalid   = tag_q[MEM_LAT];
    // RAM data is passed through in its valid cycle and held otherwise
    assign vga_rdata    = tag_q[MEM_LAT] ? mem_rdata : rdata_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 24;
    localparam int MEM_LAT = 1;
    localparam int DEPTH   = 1 << (ADDR_W + 1);

    logic              clk = 1'b0;
    logic              reset, image_select, frame_start;
    logic              vga_req, vga_gnt, vga_rvalid;
    logic [ADDR_W-1:0] vga_addr, wr_addr;
    logic [DATA_W-1:0] vga_rdata, wr_data, mem_wdata, mem_rdata;
    logic              wr_req, wr_gnt, mem_we, front_buf, swap_pending;
    logic [ADDR_W:0]   mem_addr;

    always #5 clk = ~clk;

    vga_fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset), .image_select(image_select), .frame_start(frame_start),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .front_buf(front_buf), .swap_pending(swap_pending)
    );

    // Power-on contents of the RAM; one cell carries the known read pattern
    function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W:0] a);
        if (a == 17'h00010) return 24'hABCDEF;
        return {a ^ 17'h1A5A5, 7'h33};
    endfunction

    // Synchronous RAM with MEM_LAT cycles of read latency
    logic [DATA_W-1:0] ram [DEPTH];
    bit                ram_wr [DEPTH];
    logic [DATA_W-1:0] rd_pipe [MEM_LAT];
    assign mem_rdata = rd_pipe[MEM_LAT-1];
    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr]    <= mem_wdata;
            ram_wr[mem_addr] <= 1'b1;
        end
        rd_pipe[0] <= ram_wr[mem_addr] ? ram[mem_addr] : init_val(mem_addr);
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    // Reference model: image contents, display state and pending returns
    typedef struct { int due; logic [DATA_W-1:0] data; } rd_exp_t;
    logic [DATA_W-1:0] ref_mem [DEPTH];
    bit                ref_wr [DEPTH];
    rd_exp_t           exp_q [$];
    logic              m_front = 1'b0, m_pend = 1'b0, m_we = 1'b0;
    logic [ADDR_W:0]   m_addr = '0;
    logic [DATA_W-1:0] m_wdata = '0, m_hold = '0;
    int                cyc = 0;
    int                n_tests = 0, n_fail = 0;
    logic              sel_v = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_val(input logic [ADDR_W:0] a);
        return ref_wr[a] ? ref_mem[a] : init_val(a);
    endfunction

    // Advance the model across one clock edge using this cycle's inputs
    task automatic model_edge(input logic rst, sel, fs, vr, input logic [ADDR_W-1:0] va,
                              input logic wr, input logic [ADDR_W-1:0] wa,
                              input logic [DATA_W-1:0] wd);
        cyc++;
        if (rst) begin
            m_front = 1'b0; m_pend = 1'b0; m_addr = '0; m_we = 1'b0;
            m_wdata = '0; m_hold = '0; exp_q.delete();
        end else begin
            if (vr) begin
                m_addr = {m_front, va};
                m_we   = 1'b0;
                exp_q.push_back('{cyc + MEM_LAT, ref_val({m_front, va})});
            end else if (wr) begin
                m_addr = {~m_front, wa};
                m_we   = 1'b1;
                m_wdata = wd;
                ref_mem[{~m_front, wa}] = wd;
                ref_wr[{~m_front, wa}]  = 1'b1;
            end else begin
                m_we = 1'b0;
            end
            if (!m_pend)              m_pend = (sel != m_front);
            else if (sel == m_front)  m_pend = 1'b0;
            else if (fs) begin
                m_front = ~m_front;
                m_pend  = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive, check grants, clock, check registered outputs
    task automatic run_cycle(input logic rst, sel, fs, vr, input logic [ADDR_W-1:0] va,
                             input logic wr, input logic [ADDR_W-1:0] wa,
                             input logic [DATA_W-1:0] wd);
        logic exp_rv;
        reset = rst; image_select = sel; frame_start = fs;
        vga_req = vr; vga_addr = va; wr_req = wr; wr_addr = wa; wr_data = wd;
        #1;
        check_val("vga_gnt", {31'd0, vga_gnt}, {31'd0, vr});
        check_val("wr_gnt", {31'd0, wr_gnt}, {31'd0, wr & ~vr});
        @(posedge clk);
        model_edge(rst, sel, fs, vr, va, wr, wa, wd);
        @(negedge clk);
        exp_rv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        if (exp_rv) begin
            m_hold = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        check_val("vga_rvalid", {31'd0, vga_rvalid}, {31'd0, exp_rv});
        check_val("vga_rdata", {8'd0, vga_rdata}, {8'd0, m_hold});
        check_val("front_buf", {31'd0, front_buf}, {31'd0, m_front});
        check_val("swap_pending", {31'd0, swap_pending}, {31'd0, m_pend});
        check_val("mem_addr", {15'd0, mem_addr}, {15'd0, m_addr});
        check_val("mem_we", {31'd0, mem_we}, {31'd0, m_we});
        check_val("mem_wdata", {8'd0, mem_wdata}, {8'd0, m_wdata});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(1'b0, sel_v, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 24'h0);
    endtask

    initial begin
        logic              wr_pend, vr_on, rst_r, fs_r, vr_r;
        logic [ADDR_W-1:0] wa_r, va_r;
        logic [DATA_W-1:0] wd_r;

        // Reset held two cycles, then idle
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 24'h0);
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 24'h0);
        check_val("reset_front", {31'd0, front_buf}, 32'd0);
        check_val("reset_mem_addr", {15'd0, mem_addr}, 32'd0);
        idle(10);

        // Single read latency with known data
        run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 16'h0, 24'h0);
        check_val("lat_mem_addr", {15'd0, mem_addr}, 32'h00010);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 24'h0);
        check_val("lat_rvalid", {31'd0, vga_rvalid}, 32'd1);
        check_val("lat_rdata", {8'd0, vga_rdata}, 32'hABCDEF);
        idle(3);

        // Contention: writer waits four cycles, then lands in the back buffer
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'(i), 1'b1, 16'h1234, 24'h55AA33);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1234, 24'h55AA33);
        check_val("cont_mem_addr", {15'd0, mem_addr}, 32'h11234);
        check_val("cont_mem_we", {31'd0, mem_we}, 32'd1);
        idle(3);

        // Back-to-back reads of addresses 0..7
        for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'(i), 1'b0, 16'h0, 24'h0);
        idle(4);

        // Swap request, pending until frame_start
        sel_v = 1'b1;
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 24'h0);
        check_val("swap_pend_set", {31'd0, swap_pending}, 32'd1);
        check_val("swap_front_old", {31'd0, front_buf}, 32'd0);
        idle(14);
        run_cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 24'h0);
        check_val("swap_front_new", {31'd0, front_buf}, 32'd1);
        check_val("swap_pend_clr", {31'd0, swap_pending}, 32'd0);
        run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h0042, 24'h010203);
        check_val("swap_wr_buf", {15'd0, mem_addr}, 32'h00042);
        idle(2);

        // Reset one cycle after a read grant suppresses its return
        run_cycle(1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 1'b0, 16'h0, 24'h0);
        sel_v = 1'b0;
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 24'h0);
        check_val("rst_read_rvalid", {31'd0, vga_rvalid}, 32'd0);
        idle(4);

        // Swap request cancelled before any frame_start
        sel_v = 1'b1; idle(3);
        sel_v = 1'b0; idle(1);
        check_val("cancel_pend", {31'd0, swap_pending}, 32'd0);
        check_val("cancel_front", {31'd0, front_buf}, 32'd0);
        idle(2);

        // Randomized traffic; an ungranted write is held unchanged
        wr_pend = 1'b0; vr_on = 1'b0; wa_r = '0; wd_r = '0;
        for (int i = 0; i < 1500; i++) begin
            if (!wr_pend && ($urandom_range(2) == 0)) begin
                wr_pend = 1'b1;
                wa_r = 16'($urandom);
                wd_r = 24'($urandom);
            end
            if ($urandom_range(7) == 0) vr_on = ~vr_on;
            vr_r  = vr_on & ($urandom_range(5) != 0);
            va_r  = 16'($urandom);
            if ($urandom_range(29) == 0) sel_v = ~sel_v;
            fs_r  = ($urandom_range(24) == 0);
            rst_r = ($urandom_range(399) == 0);
            run_cycle(rst_r, sel_v, fs_r, vr_r, va_r, wr_pend, wa_r, wd_r);
            if (wr_pend && !vr_r) wr_pend = 1'b0;
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM between the VGA scan-out fetcher (read-only, real-time) and an image writer (write-only).
- Implements double buffering: the RAM holds two images, and the image_select input picks the displayed (front) image.
- Buffer swaps take effect only at frame start, so the display never tears.
- Sits between the VGA pixel pipeline and the frame memory in the VGA memory subsystem.

Parameters:
- ADDR_W, 16, pixel address width within one image buffer
- DATA_W, 24, pixel word width (R,G,B 8 bits each)
- MEM_LAT, 1, RAM read latency in cycles from registered address to mem_rdata valid (1..4)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- image_select  in  1  requested front buffer (level)
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- vga_req  in  1  scan-out read request
- vga_addr  in  ADDR_W  scan-out pixel address
- vga_gnt  out  1  read request accepted this cycle
- vga_rvalid  out  1  vga_rdata valid
- vga_rdata  out  DATA_W  pixel read data
- wr_req  in  1  writer request
- wr_addr  in  ADDR_W  write pixel address
- wr_data  in  DATA_W  write pixel data
- wr_gnt  out  1  write accepted this cycle
- mem_addr  out  ADDR_W+1  RAM address, MSB = buffer select
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data
- front_buf  out  1  buffer currently displayed
- swap_pending  out  1  image_select differs from front_buf, waiting for frame_start

Behaviour:
- Reset values:
  - All outputs are 0, with front_buf=0, swap_pending=0 and mem_addr=0.
  - The read-tag pipeline is cleared, so no vga_rvalid is produced for reads in flight when reset asserts.
- Arbitration (combinational, same cycle):
  - vga_gnt = vga_req.
  - wr_gnt = wr_req & ~vga_req.
  - The VGA side has strict priority.
  - A request not granted must be held by its requester. The arbiter keeps no queue.
- Memory stage (registered, one cycle after grant):
  - Granted read: mem_addr={front_buf, vga_addr}, mem_we=0.
  - Granted write: mem_addr={~front_buf, wr_addr}, mem_we=1, mem_wdata=wr_data.
  - No grant: mem_we=0 and mem_addr holds its last value.
  - The buffer bit is sampled in the grant cycle.
- Read return:
  - A read granted in cycle N gives vga_rvalid=1 in cycle N+1+MEM_LAT, with vga_rdata=mem_rdata.
  - Valid tags are tracked by a MEM_LAT+1 deep shift register, which accepts one read per cycle.
  - vga_rdata holds its last value when vga_rvalid=0.
- Swap state machine, states SHOW0, SHOW1, PEND0, PEND1 (PENDx = showing x, swap requested):
  - SHOWx to PENDx when image_select != x.
  - PENDx to SHOWx when image_select returns to x before any frame_start (request cancelled).
  - PENDx to SHOW(~x) in the cycle after frame_start=1.
  - front_buf = x in SHOWx and PENDx. swap_pending = 1 in PEND states.
  - frame_start in a SHOW state has no effect.
- Simultaneous events:
  - A grant in the same cycle as the swapping frame_start uses the pre-swap front_buf.
  - Reads already in flight complete with their sampled buffer.
  - image_select toggling and frame_start in the same cycle: the transition is evaluated on the registered state, so the swap happens at the next frame_start.
- Writer starvation is permitted. Writes progress during blanking, when vga_req=0.

Test Plan:
- Reset then idle: reset held 2 cycles, then released -> all outputs 0, front_buf=0, no vga_rvalid for 10 cycles.
- Read latency: MEM_LAT=1, vga_req=1, vga_addr=0x0010 for 1 cycle at N, RAM model holds 0xABCDEF at {0,0x0010} -> mem_addr=0x00010 at N+1, vga_rvalid=1 and vga_rdata=0xABCDEF at N+2.
- Contention: vga_req and wr_req both high 4 cycles, then vga_req low -> wr_gnt=0 for 4 cycles, then 1; the write lands at {1,wr_addr} with mem_we=1 one cycle after wr_gnt.
- Back-to-back reads: vga_req high 8 cycles, addresses 0..7 -> 8 consecutive vga_rvalid pulses with data in address order, no gaps.
- Swap timing:
  - image_select=1 at cycle 5 -> swap_pending=1 from cycle 6, front_buf stays 0.
  - frame_start pulse at cycle 20 -> front_buf=1 and swap_pending=0 from cycle 21.
  - Subsequent writes target buffer 0.
- Swap cancel and reset mid-read:
  - image_select 0 to 1 to 0 with no frame_start -> front_buf stays 0, swap_pending drops.
  - Reset asserted 1 cycle after a read grant -> no vga_rvalid for that read.
